fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of decode.
- Owns the PC, selects the next PC from decode redirects (branch, jump, jr), and drives a single-outstanding instruction-memory handshake.
- Presents instrD, pc_plus_4_decoded and validD to decode.
- Buffers one returned instruction while decode is stalled, and squashes in-flight fetches on redirect.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, word inserted into IF/ID on bubble or flush.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stallD  in  1  hazard unit: hold IF/ID and PC this cycle.
- pcsrcD  in  1  branch taken in decode.
- branch_addrD  in  32  branch target.
- jumpD  in  1  j/jal in decode.
- jump_addrD  in  32  jump target.
- jrD  in  1  jr in decode.
- jr_addrD  in  32  jr target.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address (= PC).
- imem_ready  in  1  imem_rdata valid this cycle; completes the request.
- imem_rdata  in  32  fetched word.
- instrD  out  32  IF/ID instruction.
- pc_plus_4_decoded  out  32  IF/ID PC+4.
- validD  out  1  IF/ID holds a real instruction.
- fetch_busy  out  1  high while a request is outstanding without response (FETCH & !imem_ready, or SQUASH).

Behaviour:
- Reset (rst high at an edge):
  - PC=RESET_PC, state=FETCH.
  - instrD=NOP_INSTR, pc_plus_4_decoded=0, validD=0.
  - Holding buffer and pending target cleared.
  - imem_req=0 while rst is high; 1 on the first cycle after.
  - Reset overrides everything, including a mid-transaction ready.
- Redirect = !stallD & (jrD | jumpD | pcsrcD).
  - Target priority: jr_addrD > jump_addrD > branch_addrD.
  - Redirect while stallD=1 is ignored; decode re-presents it.
- Flush: redirect loads IF/ID with NOP_INSTR, validD=0, pc_plus_4_decoded unchanged.
- Bubble: when !stallD and no instruction is delivered, IF/ID gets NOP_INSTR with validD=0.
- stallD=1 holds IF/ID (instrD, pc_plus_4_decoded, validD) unchanged.
- imem_req = (state==FETCH | state==SQUASH) & !rst.
- imem_addr = PC. It must stay stable from request until the cycle imem_ready=1.
- One request outstanding at most. Zero-wait memory (ready in the same cycle) sustains 1 instr/cycle.
- State FETCH:
  - ready & redirect: PC<=target, flush, stay FETCH; rdata dropped.
  - ready & !redirect & !stallD: IF/ID<={imem_rdata, PC+4}, validD=1, PC<=PC+4, stay FETCH.
  - ready & stallD: buf<=imem_rdata, PC unchanged, go HOLD.
  - !ready & redirect: pend<=target, flush, go SQUASH.
  - !ready otherwise: bubble if !stallD, stay FETCH.
- State HOLD (imem_req=0):
  - redirect: PC<=target, flush, go FETCH; buf discarded.
  - !stallD: IF/ID<={buf, PC+4}, validD=1, PC<=PC+4, go FETCH.
  - stallD: stay HOLD.
- State SQUASH (request for the old PC still held):
  - A further redirect overwrites pend (latest wins); IF/ID flushed again.
  - Other non-stalled cycles insert a bubble.
  - ready: rdata dropped, PC<=pend, go FETCH.
- Arithmetic: PC+4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0. No alignment check; targets are used as given.
- fetch_busy is combinational from state and imem_ready.

Decomposition:
- Shared package/header holds:
  - state encoding FETCH=2'd0, HOLD=2'd1, SQUASH=2'd2;
  - NOP_INSTR default;
  - RESET_PC default.
- One natural sub-module: fetch_pc_sel, a combinational redirect/target priority mux that outputs redirect and target.
- PC, FSM, buffer and IF/ID registers live in fetch_stage.

Test Plan:
1. Reset then zero-wait memory (imem_ready tied 1, rdata=addr) -> imem_addr 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; instrD lags by one cycle, pc_plus_4_decoded=addr+4, validD=1.
2. Memory latency 3 cycles -> fetch_busy high for 2 cycles per fetch; IF/ID shows NOP with validD=0 during the wait; imem_addr stable throughout.
3. ready arrives with stallD=1 for 2 cycles -> state HOLD, imem_req=0, instrD unchanged; after stallD drops, instrD=buffered word and PC advances by 4.
4. pcsrcD=1, branch_addrD=0x00400100 while a request to 0x00400010 is pending -> SQUASH; the 0x00400010 response is dropped; next imem_addr=0x00400100; validD=0 during the squash.
5. jrD=1 (0x00400200) and jumpD=1 (0x00400300) in the same cycle, no stall -> next fetch address 0x00400200; IF/ID flushed.
6. PC=0xFFFFFFFC, ready -> next PC 0x00000000, pc_plus_4_decoded=0. Then rst asserted during a pending request -> PC=0x00400000, validD=0 at the next edge.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared encodings and defaults for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] SQUASH = 2'd2;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus_4;
  } ifid_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Single-outstanding instruction-memory handshake between fetch and imem.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_pc_sel.sv
// Decode redirect detection and target priority (jr > jump > branch).
module fetch_pc_sel (
  input  logic        stallD,
  input  logic        pcsrcD,
  input  logic [31:0] branch_addrD,
  input  logic        jumpD,
  input  logic [31:0] jump_addrD,
  input  logic        jrD,
  input  logic [31:0] jr_addrD,
  output logic        redirect,
  output logic [31:0] target
);

  always_comb begin
    target = branch_addrD;
    if (jrD)
      target = jr_addrD;
    else if (jumpD)
      target = jump_addrD;
  end

  // A stalled decode re-presents its redirect later, so it is ignored now.
  assign redirect = !stallD && (jrD || jumpD || pcsrcD);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with PC, one-entry return buffer, squash tracking and IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stallD,
  input  logic         pcsrcD,
  input  logic [31:0]  branch_addrD,
  input  logic         jumpD,
  input  logic [31:0]  jump_addrD,
  input  logic         jrD,
  input  logic [31:0]  jr_addrD,
  fetch_stage_if.master imem,
  output logic [31:0]  instrD,
  output logic [31:0]  pc_plus_4_decoded,
  output logic         validD,
  output logic         fetch_busy
);

  logic [1:0]  state_p0;
  logic [31:0] pc_p0;
  logic [31:0] buf_p0;
  logic [31:0] pend_p0;
  ifid_t       ifid_p1;
  logic        vld_p1;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus_4;

  fetch_pc_sel u_pc_sel (
    .stallD       (stallD),
    .pcsrcD       (pcsrcD),
    .branch_addrD (branch_addrD),
    .jumpD        (jumpD),
    .jump_addrD   (jump_addrD),
    .jrD          (jrD),
    .jr_addrD     (jr_addrD),
    .redirect     (redirect),
    .target       (target)
  );

  assign pc_plus_4      = pc_p0 + 32'd4;
  assign imem.imem_req  = ((state_p0 == FETCH) || (state_p0 == SQUASH)) && !rst;
  assign imem.imem_addr = pc_p0;
  assign fetch_busy     = ((state_p0 == FETCH) && !imem.imem_ready) || (state_p0 == SQUASH);

  // ---- PC / FSM stage feeding the IF/ID register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= FETCH;
      pc_p0    <= RESET_PC;
      buf_p0   <= '0;
      pend_p0  <= '0;
      ifid_p1  <= '{instr: NOP_INSTR, pc_plus_4: 32'd0};
      vld_p1   <= 1'b0;
    end else begin
      case (state_p0)
        FETCH: begin
          if (imem.imem_ready) begin
            if (redirect) begin
              pc_p0         <= target;
              ifid_p1.instr <= NOP_INSTR;
              vld_p1        <= 1'b0;
            end else if (!stallD) begin
              ifid_p1 <= '{instr: imem.imem_rdata, pc_plus_4: pc_plus_4};
              vld_p1  <= 1'b1;
              pc_p0   <= pc_plus_4;
            end else begin
              buf_p0   <= imem.imem_rdata;
              state_p0 <= HOLD;
            end
          end else if (redirect) begin
            pend_p0       <= target;
            ifid_p1.instr <= NOP_INSTR;
            vld_p1        <= 1'b0;
            state_p0      <= SQUASH;
          end else if (!stallD) begin
            ifid_p1.instr <= NOP_INSTR;
            vld_p1        <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_p0         <= target;
            ifid_p1.instr <= NOP_INSTR;
            vld_p1        <= 1'b0;
            state_p0      <= FETCH;
          end else if (!stallD) begin
            ifid_p1  <= '{instr: buf_p0, pc_plus_4: pc_plus_4};
            vld_p1   <= 1'b1;
            pc_p0    <= pc_plus_4;
            state_p0 <= FETCH;
          end
        end
        SQUASH: begin
          // The old-PC request stays on the bus until memory answers; its data is dropped.
          if (redirect)
            pend_p0 <= target;
          if (!stallD) begin
            ifid_p1.instr <= NOP_INSTR;
            vld_p1        <= 1'b0;
          end
          if (imem.imem_ready) begin
            pc_p0    <= redirect ? target : pend_p0;
            state_p0 <= FETCH;
          end
        end
        default: state_p0 <= FETCH;
      endcase
    end
  end

  assign instrD            = ifid_p1.instr;
  assign pc_plus_4_decoded = ifid_p1.pc_plus_4;
  assign validD            = vld_p1;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a delivery scoreboard and separate monitor.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        stallD, pcsrcD, jumpD, jrD;
  logic [31:0] branch_addrD, jump_addrD, jr_addrD;
  logic [31:0] instrD, pc_plus_4_decoded;
  logic        validD, fetch_busy;

  fetch_stage_if imem_bus ();

  fetch_stage dut (
    .clk               (clk),
    .rst               (rst),
    .stallD            (stallD),
    .pcsrcD            (pcsrcD),
    .branch_addrD      (branch_addrD),
    .jumpD             (jumpD),
    .jump_addrD        (jump_addrD),
    .jrD               (jrD),
    .jr_addrD          (jr_addrD),
    .imem              (imem_bus),
    .instrD            (instrD),
    .pc_plus_4_decoded (pc_plus_4_decoded),
    .validD            (validD),
    .fetch_busy        (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    vectors = 0;
  int    miscompares = 0;
  ifid_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Registers update at the posedge; inputs change 2 time units later.
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_redirects();
    pcsrcD = 1'b0; jumpD = 1'b0; jrD = 1'b0;
  endtask

  // Monitor: a non-stalled, non-reset edge that leaves validD high is a new delivery.
  always @(posedge clk) begin
    logic  st, r;
    ifid_t e;
    st = stallD;
    r  = rst;
    #1;
    if (!r && !st && validD === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_delivery: got instr %h pc4 %h, expected no delivery", instrD, pc_plus_4_decoded);
      end else begin
        e = exp_q.pop_front();
        if (instrD !== e.instr || pc_plus_4_decoded !== e.pc_plus_4) begin
          miscompares++;
          $display("FAIL delivery: got instr %h pc4 %h, expected instr %h pc4 %h",
                   instrD, pc_plus_4_decoded, e.instr, e.pc_plus_4);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; stallD = 1'b0; clear_redirects();
    branch_addrD = '0; jump_addrD = '0; jr_addrD = '0;
    imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = '0;

    cycle(); cycle();
    #1;
    check("reset_req", {31'd0, imem_bus.imem_req}, 32'd0);
    check("reset_valid", {31'd0, validD}, 32'd0);
    check("reset_instr", instrD, 32'h0);
    check("reset_pc4", pc_plus_4_decoded, 32'h0);

    rst = 1'b0;
    #1;
    check("post_reset_req", {31'd0, imem_bus.imem_req}, 32'd1);
    check("post_reset_addr", imem_bus.imem_addr, 32'h0040_0000);

    // Zero-wait memory, rdata = address
    imem_bus.imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a;
      a = 32'h0040_0000 + 32'(4 * i);
      #1;
      check("zw_addr", imem_bus.imem_addr, a);
      imem_bus.imem_rdata = a;
      exp_q.push_back('{instr: a, pc_plus_4: a + 32'd4});
      cycle();
    end

    // Three-cycle latency at 0x0040000C
    imem_bus.imem_ready = 1'b0;
    #1;
    check("lat_busy0", {31'd0, fetch_busy}, 32'd1);
    cycle();
    #1;
    check("lat_bubble_valid", {31'd0, validD}, 32'd0);
    check("lat_bubble_instr", instrD, 32'h0);
    check("lat_busy1", {31'd0, fetch_busy}, 32'd1);
    check("lat_addr_stable", imem_bus.imem_addr, 32'h0040_000C);
    cycle();
    imem_bus.imem_ready = 1'b1; imem_bus.imem_rdata = 32'hAAAA_0001;
    #1;
    check("lat_busy_done", {31'd0, fetch_busy}, 32'd0);
    check("lat_addr_final", imem_bus.imem_addr, 32'h0040_000C);
    exp_q.push_back('{instr: 32'hAAAA_0001, pc_plus_4: 32'h0040_0010});
    cycle();

    // Ready while stalled: buffer into HOLD for two cycles
    stallD = 1'b1; imem_bus.imem_rdata = 32'hBBBB_0002;
    #1;
    check("hold_addr", imem_bus.imem_addr, 32'h0040_0010);
    cycle();
    imem_bus.imem_ready = 1'b0;
    #1;
    check("hold_req", {31'd0, imem_bus.imem_req}, 32'd0);
    check("hold_instr", instrD, 32'hAAAA_0001);
    cycle();
    #1;
    check("hold_req2", {31'd0, imem_bus.imem_req}, 32'd0);
    check("hold_valid", {31'd0, validD}, 32'd1);
    stallD = 1'b0;
    exp_q.push_back('{instr: 32'hBBBB_0002, pc_plus_4: 32'h0040_0014});
    cycle();
    #1;
    check("hold_release_addr", imem_bus.imem_addr, 32'h0040_0014);
    check("hold_release_req", {31'd0, imem_bus.imem_req}, 32'd1);

    // Branch while a request is pending -> SQUASH
    cycle();
    pcsrcD = 1'b1; branch_addrD = 32'h0040_0100;
    cycle();
    clear_redirects();
    #1;
    check("sq_busy", {31'd0, fetch_busy}, 32'd1);
    check("sq_req", {31'd0, imem_bus.imem_req}, 32'd1);
    check("sq_addr_old", imem_bus.imem_addr, 32'h0040_0014);
    check("sq_valid", {31'd0, validD}, 32'd0);
    imem_bus.imem_ready = 1'b1; imem_bus.imem_rdata = 32'hDEAD_0003;
    #1;
    check("sq_busy_on_ready", {31'd0, fetch_busy}, 32'd1);
    cycle();
    #1;
    check("sq_new_addr", imem_bus.imem_addr, 32'h0040_0100);
    check("sq_dropped_valid", {31'd0, validD}, 32'd0);

    // jr, jump and branch together: jr wins
    imem_bus.imem_rdata = 32'h1111_0004;
    jrD = 1'b1; jr_addrD = 32'h0040_0200;
    jumpD = 1'b1; jump_addrD = 32'h0040_0300;
    pcsrcD = 1'b1; branch_addrD = 32'h0040_0400;
    cycle();
    clear_redirects();
    #1;
    check("prio_addr", imem_bus.imem_addr, 32'h0040_0200);
    check("prio_flush_valid", {31'd0, validD}, 32'd0);
    check("prio_flush_instr", instrD, 32'h0);

    // Redirect under stall is ignored
    imem_bus.imem_ready = 1'b0; stallD = 1'b1;
    pcsrcD = 1'b1; branch_addrD = 32'h0040_0500;
    cycle();
    #1;
    check("stalled_redirect_addr", imem_bus.imem_addr, 32'h0040_0200);
    check("stalled_redirect_req", {31'd0, imem_bus.imem_req}, 32'd1);
    clear_redirects(); stallD = 1'b0;

    // PC wrap at 0xFFFFFFFC
    imem_bus.imem_ready = 1'b1;
    jumpD = 1'b1; jump_addrD = 32'hFFFF_FFFC;
    cycle();
    clear_redirects();
    #1;
    check("wrap_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
    imem_bus.imem_rdata = 32'h2222_0005;
    exp_q.push_back('{instr: 32'h2222_0005, pc_plus_4: 32'h0000_0000});
    cycle();
    #1;
    check("wrap_next_addr", imem_bus.imem_addr, 32'h0000_0000);
    check("wrap_pc4", pc_plus_4_decoded, 32'h0000_0000);

    // Reset during a pending request, with ready arriving in the reset cycle
    imem_bus.imem_ready = 1'b0;
    cycle();
    #1;
    check("pend_busy", {31'd0, fetch_busy}, 32'd1);
    rst = 1'b1; imem_bus.imem_ready = 1'b1; imem_bus.imem_rdata = 32'h3333_0006;
    #1;
    check("rst_req_low", {31'd0, imem_bus.imem_req}, 32'd0);
    cycle();
    #1;
    check("rst_valid", {31'd0, validD}, 32'd0);
    check("rst_instr", instrD, 32'h0);
    rst = 1'b0; imem_bus.imem_ready = 1'b0;
    #1;
    check("rst_pc", imem_bus.imem_addr, 32'h0040_0000);
    check("rst_req_high", {31'd0, imem_bus.imem_req}, 32'd1);

    cycle();
    #5;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
